// File: rtl/fx_uart_phy.sv
// fx_uart_phy: byte-level UART PHY for the FX command link (RX deserialiser, TX serialiser).
// Latency: RX strobe one cycle after the stop-bit sample; TX line goes low the cycle after tx_vld.
// Backpressure: none on RX; TX has a 1-deep hold slot, a third request while full is dropped (tx_ovf).
//
// Ports:
//   clk_sys, rst_n        system clock, asynchronous active-low reset
//   uart_rx / uart_tx     serial pins (idle high); uart_rx is asynchronous to clk_sys
//   rx_data, rx_vld       received byte and its one-cycle strobe
//   rx_err                one-cycle strobe on framing or parity error
//   tx_data, tx_vld       byte to send, one-cycle request
//   tx_busy               frame on the line or hold slot occupied
//   tx_ovf                one-cycle strobe when a request is dropped
// Optional feature: define FX_UART_PARITY_EN for an even-parity bit after the data bits.
module fx_uart_phy #(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic [7:0] rx_data,
   output logic       rx_vld,
   output logic       rx_err,
   input  logic [7:0] tx_data,
   input  logic       tx_vld,
   output logic       tx_busy,
   output logic       tx_ovf
);

   localparam logic [15:0] DIV  = 16'(BAUD_DIV);
   localparam logic [15:0] HALF = 16'(BAUD_DIV / 2);

   // ------------------------------------------------------------------
   // RX path
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      R_IDLE  = 3'd0,
      R_START = 3'd1,
      R_DATA  = 3'd2,
      R_PAR   = 3'd3,
      R_STOP  = 3'd4,
      R_BRK   = 3'd5
   } rx_state_t;

   rx_state_t   rx_state;
   logic        rx_s1, rx_s2, rx_prev;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_idx;
   logic [7:0]  rx_sr;
   logic        rx_exp;
   logic        rx_fall;
`ifdef FX_UART_PARITY_EN
   logic        par_ok;
`endif

   // Sample point reached when the counter is at 1; loading HALF in the
   // start-detect cycle puts the first sample exactly HALF cycles later.
   assign rx_exp  = (rx_cnt == 16'd1);
   assign rx_fall = rx_prev & ~rx_s2;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= R_IDLE;
         rx_cnt   <= 16'd0;
         rx_idx   <= 3'd0;
         rx_sr    <= 8'h00;
         rx_data  <= 8'h00;
         rx_vld   <= 1'b0;
         rx_err   <= 1'b0;
`ifdef FX_UART_PARITY_EN
         par_ok   <= 1'b1;
`endif
      end else begin
         rx_s1   <= uart_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         rx_vld  <= 1'b0;
         rx_err  <= 1'b0;
         if (rx_state != R_IDLE && rx_state != R_BRK && !rx_exp)
            rx_cnt <= rx_cnt - 16'd1;
         case (rx_state)
            R_IDLE: begin
               if (rx_fall) begin
                  rx_cnt   <= HALF;
                  rx_state <= R_START;
               end
            end
            R_START: begin
               if (rx_exp) begin
                  if (!rx_s2) begin
                     rx_cnt   <= DIV;
                     rx_idx   <= 3'd0;
                     rx_state <= R_DATA;
                  end else begin
                     rx_state <= R_IDLE;   // glitch shorter than half a bit
                  end
               end
            end
            R_DATA: begin
               if (rx_exp) begin
                  rx_sr  <= {rx_s2, rx_sr[7:1]};
                  rx_cnt <= DIV;
                  rx_idx <= rx_idx + 3'd1;
                  if (rx_idx == 3'd7) begin
`ifdef FX_UART_PARITY_EN
                     rx_state <= R_PAR;
`else
                     rx_state <= R_STOP;
`endif
                  end
               end
            end
`ifdef FX_UART_PARITY_EN
            R_PAR: begin
               if (rx_exp) begin
                  par_ok   <= (rx_s2 == ^rx_sr);
                  rx_cnt   <= DIV;
                  rx_state <= R_STOP;
               end
            end
`endif
            R_STOP: begin
               if (rx_exp) begin
                  if (!rx_s2) begin
                     rx_err   <= 1'b1;
                     rx_state <= R_BRK;    // hold off until the line recovers
`ifdef FX_UART_PARITY_EN
                  end else if (!par_ok) begin
                     rx_err   <= 1'b1;
                     rx_state <= R_IDLE;
`endif
                  end else begin
                     rx_data  <= rx_sr;
                     rx_vld   <= 1'b1;
                     rx_state <= R_IDLE;
                  end
               end
            end
            R_BRK: begin
               if (rx_s2)
                  rx_state <= R_IDLE;
            end
            default: rx_state <= R_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // TX path
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      T_IDLE  = 3'd0,
      T_START = 3'd1,
      T_DATA  = 3'd2,
      T_PAR   = 3'd3,
      T_STOP  = 3'd4
   } tx_state_t;

   tx_state_t   tx_state;
   logic [15:0] tx_cnt;
   logic [2:0]  tx_idx;
   logic [7:0]  tx_sr;
   logic        hold_full;
   logic [7:0]  hold_dat;
   logic        tx_exp;
   logic        stop_end;
   logic        tx_load;
   logic [7:0]  load_dat;
`ifdef FX_UART_PARITY_EN
   logic        tx_par;
`endif

   assign tx_exp   = (tx_cnt == 16'd1);
   assign stop_end = (tx_state == T_STOP) && tx_exp;
   // A new frame starts from idle on a request, or straight out of the stop
   // bit when another byte is waiting (held byte first, else the new request).
   assign tx_load  = ((tx_state == T_IDLE) && tx_vld) || (stop_end && (hold_full || tx_vld));
   assign load_dat = hold_full ? hold_dat : tx_data;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         tx_state  <= T_IDLE;
         tx_cnt    <= 16'd0;
         tx_idx    <= 3'd0;
         tx_sr     <= 8'h00;
         hold_full <= 1'b0;
         hold_dat  <= 8'h00;
         uart_tx   <= 1'b1;
         tx_busy   <= 1'b0;
         tx_ovf    <= 1'b0;
`ifdef FX_UART_PARITY_EN
         tx_par    <= 1'b0;
`endif
      end else begin
         tx_ovf <= 1'b0;

         // Requests arriving while a frame is on the line
         if (tx_vld && tx_state != T_IDLE) begin
            if (stop_end) begin
               // Hold slot is freed this cycle (or the byte goes straight to the shifter)
               if (hold_full) begin
                  hold_dat <= tx_data;
               end
               hold_full <= hold_full;
            end else if (!hold_full) begin
               hold_full <= 1'b1;
               hold_dat  <= tx_data;
            end else begin
               tx_ovf <= 1'b1;
            end
         end else if (stop_end && hold_full) begin
            hold_full <= 1'b0;
         end

         if (tx_state != T_IDLE && !tx_exp)
            tx_cnt <= tx_cnt - 16'd1;

         if (tx_load) begin
            tx_sr    <= load_dat;
`ifdef FX_UART_PARITY_EN
            tx_par   <= ^load_dat;
`endif
            tx_cnt   <= DIV;
            uart_tx  <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= T_START;
         end else if (tx_exp) begin
            tx_cnt <= DIV;
            case (tx_state)
               T_START: begin
                  uart_tx  <= tx_sr[0];
                  tx_sr    <= {1'b0, tx_sr[7:1]};
                  tx_idx   <= 3'd0;
                  tx_state <= T_DATA;
               end
               T_DATA: begin
                  if (tx_idx == 3'd7) begin
`ifdef FX_UART_PARITY_EN
                     uart_tx  <= tx_par;
                     tx_state <= T_PAR;
`else
                     uart_tx  <= 1'b1;
                     tx_state <= T_STOP;
`endif
                  end else begin
                     uart_tx <= tx_sr[0];
                     tx_sr   <= {1'b0, tx_sr[7:1]};
                     tx_idx  <= tx_idx + 3'd1;
                  end
               end
`ifdef FX_UART_PARITY_EN
               T_PAR: begin
                  uart_tx  <= 1'b1;
                  tx_state <= T_STOP;
               end
`endif
               T_STOP: begin
                  tx_busy  <= 1'b0;
                  tx_state <= T_IDLE;
               end
               default: tx_state <= T_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fx_uart_phy.sv
// tb_fx_uart_phy: directed checks of fx_uart_phy with BAUD_DIV = 16.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_fx_uart_phy;

   localparam int BD = 16;
`ifdef FX_UART_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic       clk_sys = 1'b0;
   logic       rst_n;
   logic       uart_rx;
   logic       uart_tx;
   logic [7:0] rx_data;
   logic       rx_vld;
   logic       rx_err;
   logic [7:0] tx_data;
   logic       tx_vld;
   logic       tx_busy;
   logic       tx_ovf;

   fx_uart_phy #(.BAUD_DIV(BD)) dut (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .uart_rx (uart_rx),
      .uart_tx (uart_tx),
      .rx_data (rx_data),
      .rx_vld  (rx_vld),
      .rx_err  (rx_err),
      .tx_data (tx_data),
      .tx_vld  (tx_vld),
      .tx_busy (tx_busy),
      .tx_ovf  (tx_ovf)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // RX monitor
   logic [7:0] rx_q[$];
   int         err_cnt  = 0;
   int         both_cnt = 0;
   always @(negedge clk_sys) begin
      if (rst_n === 1'b1) begin
         if (rx_vld === 1'b1) rx_q.push_back(rx_data);
         if (rx_err === 1'b1) err_cnt++;
         if (rx_vld === 1'b1 && rx_err === 1'b1) both_cnt++;
      end
   end

   typedef struct {
      logic [7:0] dat;
      logic       par;      // parity bit put on the line (parity build only)
      logic       stop;
      int         exp_vld;
      int         exp_err;
   } rx_vec_t;

   task automatic send_bit(input logic b);
      uart_rx = b;
      repeat (BD) @(negedge clk_sys);
   endtask

   task automatic send_frame(input rx_vec_t v);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(v.dat[i]);
`ifdef FX_UART_PARITY_EN
      send_bit(v.par);
`endif
      send_bit(v.stop);
   endtask

   function automatic logic exp_tx_bit(input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
`ifdef FX_UART_PARITY_EN
      if (b == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   rx_vec_t rx_tab[$];

   initial begin
      rx_vec_t v;
      int      bad[FB];
      int      busy_cnt;
      logic    busy_first, busy_after;
      int      mis, ovf_cnt;
      logic    ovf_at3;

      rx_tab.push_back('{8'h81, ^8'h81, 1'b1, 1, 0});
      rx_tab.push_back('{8'h00, ^8'h00, 1'b1, 1, 0});
      rx_tab.push_back('{8'h10, ^8'h10, 1'b1, 1, 0});
      rx_tab.push_back('{8'h5A, ^8'h5A, 1'b1, 1, 0});
`ifdef FX_UART_PARITY_EN
      rx_tab.push_back('{8'h07, 1'b0, 1'b1, 0, 1});
      rx_tab.push_back('{8'h07, 1'b1, 1'b1, 1, 0});
`endif

      rst_n   = 1'b0;
      uart_rx = 1'b1;
      tx_vld  = 1'b0;
      tx_data = 8'h00;
      repeat (3) @(negedge clk_sys);
      check("rst_uart_tx", 32'(uart_tx), 32'd1);
      check("rst_rx_data", 32'(rx_data), 32'h00);
      check("rst_rx_vld",  32'(rx_vld),  32'd0);
      check("rst_rx_err",  32'(rx_err),  32'd0);
      check("rst_tx_busy", 32'(tx_busy), 32'd0);
      check("rst_tx_ovf",  32'(tx_ovf),  32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk_sys);

      // ---------------- RX table ----------------
      foreach (rx_tab[k]) begin
         rx_q.delete();
         err_cnt = 0;
         send_frame(rx_tab[k]);
         repeat (2 * BD) @(negedge clk_sys);
         check($sformatf("rx_vec%0d_vld_cnt", k), 32'(rx_q.size()), 32'(rx_tab[k].exp_vld));
         check($sformatf("rx_vec%0d_err_cnt", k), 32'(err_cnt), 32'(rx_tab[k].exp_err));
         if (rx_tab[k].exp_vld == 1 && rx_q.size() > 0)
            check($sformatf("rx_vec%0d_data", k), 32'(rx_q[0]), 32'(rx_tab[k].dat));
      end

      // ---------------- RX short glitch ----------------
      rx_q.delete();
      err_cnt = 0;
      uart_rx = 1'b0;
      repeat (5) @(negedge clk_sys);
      uart_rx = 1'b1;
      repeat (3 * BD) @(negedge clk_sys);
      check("glitch_vld_cnt", 32'(rx_q.size()), 32'd0);
      check("glitch_err_cnt", 32'(err_cnt), 32'd0);
      v = '{8'hC3, ^8'hC3, 1'b1, 1, 0};
      send_frame(v);
      repeat (2 * BD) @(negedge clk_sys);
      check("after_glitch_vld_cnt", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) check("after_glitch_data", 32'(rx_q[0]), 32'hC3);

      // ---------------- RX framing error + break ----------------
      rx_q.delete();
      err_cnt = 0;
      v = '{8'h55, ^8'h55, 1'b0, 0, 1};
      send_frame(v);
      uart_rx = 1'b0;
      repeat (40) @(negedge clk_sys);
      uart_rx = 1'b1;
      repeat (2 * BD) @(negedge clk_sys);
      check("brk_err_cnt", 32'(err_cnt), 32'd1);
      check("brk_vld_cnt", 32'(rx_q.size()), 32'd0);
      v = '{8'h3C, ^8'h3C, 1'b1, 1, 0};
      send_frame(v);
      repeat (2 * BD) @(negedge clk_sys);
      check("brk_after_vld_cnt", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) check("brk_after_data", 32'(rx_q[0]), 32'h3C);
      check("brk_after_err_cnt", 32'(err_cnt), 32'd1);
      check("rx_vld_err_same_cycle", 32'(both_cnt), 32'd0);

      // ---------------- TX single byte 8'hA5 ----------------
      foreach (bad[b]) bad[b] = 0;
      busy_cnt = 0; busy_first = 1'b0; busy_after = 1'b1;
      for (int i = 0; i <= FB * BD + 20; i++) begin
         @(negedge clk_sys);
         if (i >= 1 && i <= FB * BD) begin
            if (uart_tx !== exp_tx_bit(8'hA5, (i - 1) / BD)) bad[(i - 1) / BD]++;
         end
         if (tx_busy === 1'b1) busy_cnt++;
         if (i == 1) busy_first = tx_busy;
         if (i == FB * BD + 1) busy_after = tx_busy;
         tx_vld  = (i == 0);
         tx_data = 8'hA5;
      end
      for (int b = 0; b < FB; b++) check($sformatf("tx_a5_bit%0d", b), 32'(bad[b]), 32'd0);
      check("tx_a5_busy_cycles", 32'(busy_cnt), 32'(FB * BD));
      check("tx_a5_busy_first", 32'(busy_first), 32'd1);
      check("tx_a5_busy_after", 32'(busy_after), 32'd0);

      // ---------------- TX back-to-back with overflow ----------------
      mis = 0; ovf_cnt = 0; ovf_at3 = 1'b0; busy_after = 1'b1;
      for (int i = 0; i <= 2 * FB * BD + 20; i++) begin
         @(negedge clk_sys);
         if (i >= 1 && i <= 2 * FB * BD) begin
            if (uart_tx !== exp_tx_bit(((i - 1) / (FB * BD) == 0) ? 8'h11 : 8'h22,
                                       ((i - 1) % (FB * BD)) / BD)) mis++;
         end else if (i > 2 * FB * BD) begin
            if (uart_tx !== 1'b1) mis++;
         end
         if (tx_ovf === 1'b1) ovf_cnt++;
         if (i == 3) ovf_at3 = tx_ovf;
         if (i == 2 * FB * BD + 1) busy_after = tx_busy;
         tx_vld  = (i <= 2);
         tx_data = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : 8'h33;
      end
      check("b2b_line_mismatches", 32'(mis), 32'd0);
      check("b2b_ovf_count", 32'(ovf_cnt), 32'd1);
      check("b2b_ovf_on_third", 32'(ovf_at3), 32'd1);
      check("b2b_busy_after", 32'(busy_after), 32'd0);

      // ---------------- Reset mid-frame ----------------
      @(negedge clk_sys);
      tx_vld = 1'b1; tx_data = 8'h00;
      @(negedge clk_sys);
      tx_vld = 1'b0;
      repeat (3 * BD) @(negedge clk_sys);
      check("midrst_line_low", 32'(uart_tx), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_uart_tx", 32'(uart_tx), 32'd1);
      check("midrst_tx_busy", 32'(tx_busy), 32'd0);
      repeat (2) @(negedge clk_sys);
      rst_n = 1'b1;
      repeat (2 * BD) @(negedge clk_sys);
      check("postrst_uart_tx", 32'(uart_tx), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
